// File: rtl/lfsr_range_rng.sv
// Free-running Fibonacci LFSR with a rejection-sampling front end that returns
// numbers uniformly below a requested limit, falling back after MAX_TRIES rejects.
module lfsr_range_rng #(
    parameter int               WIDTH     = 16,
    parameter int               OUT_W     = 6,
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(16'hABCD),
    parameter int               MAX_TRIES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    input  logic [OUT_W-1:0] limit,
    output logic             busy,
    output logic             valid,
    output logic [OUT_W-1:0] rand_out,
    output logic             fallback,
    output logic [WIDTH-1:0] lfsr_state
);

    if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 24 || WIDTH == 32)) begin : g_bad_width
        $error("lfsr_range_rng: WIDTH must be 8, 16, 24 or 32");
    end
    if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
        $error("lfsr_range_rng: OUT_W must be in 1..WIDTH");
    end
    if (SEED == {WIDTH{1'b0}}) begin : g_bad_seed
        $error("lfsr_range_rng: SEED must be non-zero");
    end
    if (MAX_TRIES < 1 || MAX_TRIES > 255) begin : g_bad_tries
        $error("lfsr_range_rng: MAX_TRIES must be in 1..255");
    end

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    localparam logic [7:0] LAST_TRY = 8'(MAX_TRIES - 1);

    // Feedback taps per width; the register is widened so every tap index is legal.
    function automatic logic lfsr_fb_f(input logic [WIDTH-1:0] s);
        logic [31:0] w;
        logic        fb;
        w = 32'(s);
        case (WIDTH)
            8:       fb = w[7]  ^ w[5]  ^ w[4]  ^ w[3];
            16:      fb = w[15] ^ w[13] ^ w[12] ^ w[10];
            24:      fb = w[23] ^ w[22] ^ w[21] ^ w[16];
            32:      fb = w[31] ^ w[21] ^ w[1]  ^ w[0];
            default: fb = 1'b0;
        endcase
        return fb;
    endfunction

    logic [WIDTH-1:0] lfsr_r;
    logic [WIDTH-1:0] lfsr_nxt_s;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [7:0]       tries_r;
    logic [7:0]       tries_nxt_s;
    logic [OUT_W-1:0] limit_q_r;
    logic [OUT_W-1:0] limit_q_nxt_s;
    logic [OUT_W-1:0] rand_r;
    logic [OUT_W-1:0] rand_nxt_s;
    logic             valid_r;
    logic             valid_nxt_s;
    logic             fallback_r;
    logic             fallback_nxt_s;
    logic [OUT_W-1:0] cand_s;
    logic             accept_s;

    assign cand_s   = lfsr_r[OUT_W-1:0];
    assign accept_s = (limit_q_r == {OUT_W{1'b0}}) || (cand_s < limit_q_r);

    // LFSR next value: seed reload wins, then the all-zero guard, then a normal shift.
    always_comb begin
        lfsr_nxt_s = lfsr_r;
        if (seed_load) begin
            if (seed_in == {WIDTH{1'b0}}) begin
                lfsr_nxt_s = SEED;
            end else begin
                lfsr_nxt_s = seed_in;
            end
        end else if (lfsr_r == {WIDTH{1'b0}}) begin
            lfsr_nxt_s = SEED;
        end else begin
            lfsr_nxt_s = {lfsr_r[WIDTH-2:0], lfsr_fb_f(lfsr_r)};
        end
    end

    // Search FSM next-state and result decode.
    always_comb begin
        state_nxt_s    = state_r;
        tries_nxt_s    = tries_r;
        limit_q_nxt_s  = limit_q_r;
        rand_nxt_s     = rand_r;
        valid_nxt_s    = 1'b0;
        fallback_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req) begin
                    limit_q_nxt_s = limit;
                    tries_nxt_s   = 8'd0;
                    state_nxt_s   = SEARCH;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            SEARCH: begin
                if (accept_s) begin
                    rand_nxt_s  = cand_s;
                    valid_nxt_s = 1'b1;
                    state_nxt_s = IDLE;
                end else if (tries_r == LAST_TRY) begin
                    // limit_q is non-zero here: a zero limit always accepts.
                    rand_nxt_s     = limit_q_r - OUT_W'(1);
                    valid_nxt_s    = 1'b1;
                    fallback_nxt_s = 1'b1;
                    state_nxt_s    = IDLE;
                end else begin
                    tries_nxt_s = tries_r + 8'd1;
                    state_nxt_s = SEARCH;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r     <= SEED;
            state_r    <= IDLE;
            tries_r    <= 8'd0;
            limit_q_r  <= {OUT_W{1'b0}};
            rand_r     <= {OUT_W{1'b0}};
            valid_r    <= 1'b0;
            fallback_r <= 1'b0;
        end else begin
            lfsr_r     <= lfsr_nxt_s;
            state_r    <= state_nxt_s;
            tries_r    <= tries_nxt_s;
            limit_q_r  <= limit_q_nxt_s;
            rand_r     <= rand_nxt_s;
            valid_r    <= valid_nxt_s;
            fallback_r <= fallback_nxt_s;
        end
    end

    assign busy       = (state_r == SEARCH);
    assign valid      = valid_r;
    assign rand_out   = rand_r;
    assign fallback   = fallback_r;
    assign lfsr_state = lfsr_r;

endmodule

// File: tb/tb_lfsr_range_rng.sv
// Directed bench for lfsr_range_rng: default instance plus a MAX_TRIES=4 instance
// sharing the same stimulus; inputs change and outputs are sampled on negedge.
module tb_lfsr_range_rng;

    logic        clk;
    logic        rst;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        req;
    logic [5:0]  limit;

    logic        busy, valid, fallback;
    logic [5:0]  rand_out;
    logic [15:0] lfsr_state;
    logic        busy4, valid4, fallback4;
    logic [5:0]  rand4;
    logic [15:0] lfsr4;

    int n_cmp = 0;
    int n_err = 0;

    lfsr_range_rng #(.WIDTH(16), .OUT_W(6), .SEED(16'hABCD), .MAX_TRIES(16)) dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
        .req(req), .limit(limit), .busy(busy), .valid(valid),
        .rand_out(rand_out), .fallback(fallback), .lfsr_state(lfsr_state)
    );

    lfsr_range_rng #(.WIDTH(16), .OUT_W(6), .SEED(16'hABCD), .MAX_TRIES(4)) dut4 (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
        .req(req), .limit(limit), .busy(busy4), .valid(valid4),
        .rand_out(rand4), .fallback(fallback4), .lfsr_state(lfsr4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        if (s == 16'h0000) return 16'hABCD;
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic test_reset;
        rst = 1'b1; seed_load = 1'b0; seed_in = 16'h0000; req = 1'b0; limit = 6'd0;
        repeat (2) @(negedge clk);
        n_cmp++; if (lfsr_state !== 16'hABCD) begin n_err++; $display("FAIL reset_lfsr: got %h want abcd", lfsr_state); end
        n_cmp++; if (lfsr4 !== 16'hABCD) begin n_err++; $display("FAIL reset_lfsr4: got %h want abcd", lfsr4); end
        n_cmp++; if ({busy, valid, fallback} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {busy, valid, fallback}); end
        n_cmp++; if (rand_out !== 6'd0) begin n_err++; $display("FAIL reset_rand: got %h want 0", rand_out); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (lfsr_state !== 16'h579A) begin n_err++; $display("FAIL run_1: got %h want 579a", lfsr_state); end
        @(negedge clk);
        n_cmp++; if (lfsr_state !== 16'hAF34) begin n_err++; $display("FAIL run_2: got %h want af34", lfsr_state); end
        n_cmp++; if ({busy, valid} !== 2'b00) begin n_err++; $display("FAIL run_idle: got %b want 00", {busy, valid}); end
    endtask

    task automatic test_seed_load;
        seed_load = 1'b1; seed_in = 16'h0000;
        @(negedge clk);
        n_cmp++; if (lfsr_state !== 16'hABCD) begin n_err++; $display("FAIL seed_zero: got %h want abcd", lfsr_state); end
        seed_in = 16'h1234;
        @(negedge clk);
        n_cmp++; if (lfsr_state !== 16'h1234) begin n_err++; $display("FAIL seed_1234: got %h want 1234", lfsr_state); end
        seed_load = 1'b0;
        @(negedge clk);
        n_cmp++; if (lfsr_state !== 16'h2469) begin n_err++; $display("FAIL seed_next: got %h want 2469", lfsr_state); end
    endtask

    task automatic test_limit0;
        seed_load = 1'b1; seed_in = 16'h1234; req = 1'b0; limit = 6'd0;
        @(negedge clk);
        seed_load = 1'b0; req = 1'b1;          // cycle T, lfsr = 1234
        @(negedge clk);                         // T+1
        req = 1'b0;
        n_cmp++; if (busy !== 1'b1 || valid !== 1'b0) begin n_err++; $display("FAIL l0_t1: got busy=%b valid=%b want 1 0", busy, valid); end
        n_cmp++; if (lfsr_state !== 16'h2469) begin n_err++; $display("FAIL l0_cand_src: got %h want 2469", lfsr_state); end
        @(negedge clk);                         // T+2
        n_cmp++; if (valid !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL l0_t2: got valid=%b busy=%b want 1 0", valid, busy); end
        n_cmp++; if (rand_out !== 6'h29) begin n_err++; $display("FAIL l0_rand: got %h want 29", rand_out); end
        n_cmp++; if (fallback !== 1'b0) begin n_err++; $display("FAIL l0_fb: got %b want 0", fallback); end
        @(negedge clk);                         // T+3
        n_cmp++; if (valid !== 1'b0 || rand_out !== 6'h29) begin n_err++; $display("FAIL l0_hold: got valid=%b rand=%h want 0 29", valid, rand_out); end
    endtask

    task automatic test_fallback;
        bit early;
        bit late;
        early = 1'b0; late = 1'b0;
        seed_load = 1'b1; seed_in = 16'h1234; req = 1'b0; limit = 6'd1;
        @(negedge clk);
        seed_load = 1'b0; req = 1'b1;           // cycle T; candidates 29,12,24,08 all rejected
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            req = (k == 2);                     // extra request while busy
            if (valid4 !== 1'b0 || busy4 !== 1'b1) early = 1'b1;
        end
        n_cmp++; if (early) begin n_err++; $display("FAIL fb_search: got early valid or busy low, want busy=1 valid=0 through T+4"); end
        @(negedge clk);                         // T+5
        req = 1'b0;
        n_cmp++; if (valid4 !== 1'b1 || fallback4 !== 1'b1) begin n_err++; $display("FAIL fb_pulse: got valid=%b fb=%b want 1 1", valid4, fallback4); end
        n_cmp++; if (rand4 !== 6'd0) begin n_err++; $display("FAIL fb_rand: got %h want 0", rand4); end
        n_cmp++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL fb_busy: got %b want 0", busy4); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (valid4 !== 1'b0 || fallback4 !== 1'b0 || busy4 !== 1'b0) late = 1'b1;
        end
        n_cmp++; if (late) begin n_err++; $display("FAIL fb_no_queue: got a second valid or busy, want none"); end
        repeat (25) @(negedge clk);            // let the MAX_TRIES=16 instance finish
    endtask

    task automatic test_back_to_back;
        logic [15:0] m_lfsr;
        logic        m_busy;
        int          m_tries;
        logic [5:0]  cand, e_rand;
        logic        e_valid, e_fb;
        int nvalid, cyc, last_v, fb_model, fb_dut;
        nvalid = 0; cyc = 0; last_v = -10; fb_model = 0; fb_dut = 0;
        e_rand = 6'd0; e_fb = 1'b0;
        seed_load = 1'b1; seed_in = 16'h1234; req = 1'b0; limit = 6'd40;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_start_idle: got busy=%b want 0", busy); end
        seed_load = 1'b0; req = 1'b1;
        m_lfsr = 16'h1234; m_busy = 1'b0; m_tries = 0;
        while (nvalid < 1000 && cyc < 8000) begin
            e_valid = 1'b0;
            if (!m_busy) begin
                m_busy = 1'b1; m_tries = 0;
            end else begin
                cand = m_lfsr[5:0];
                if (cand < 6'd40) begin
                    e_valid = 1'b1; e_rand = cand; e_fb = 1'b0; m_busy = 1'b0;
                end else if (m_tries == 15) begin
                    e_valid = 1'b1; e_rand = 6'd39; e_fb = 1'b1; m_busy = 1'b0;
                end else begin
                    m_tries++;
                end
            end
            m_lfsr = lfsr_next(m_lfsr);
            @(negedge clk);
            cyc++;
            n_cmp++; if (valid !== e_valid || lfsr_state !== m_lfsr) begin n_err++; $display("FAIL b2b_cycle %0d: got valid=%b lfsr=%h want %b %h", cyc, valid, lfsr_state, e_valid, m_lfsr); end
            if (e_valid) fb_model++;
            if (e_valid && !e_fb) fb_model--;
            if (valid === 1'b1) begin
                nvalid++;
                if (fallback === 1'b1) fb_dut++;
                n_cmp++; if (rand_out >= 6'd40) begin n_err++; $display("FAIL b2b_range: got %0d want < 40", rand_out); end
                n_cmp++; if (rand_out !== e_rand || fallback !== e_fb) begin n_err++; $display("FAIL b2b_value: got %0d fb=%b want %0d fb=%b", rand_out, fallback, e_rand, e_fb); end
                n_cmp++; if (cyc - last_v < 2) begin n_err++; $display("FAIL b2b_spacing: got %0d want >= 2", cyc - last_v); end
                last_v = cyc;
                if (nvalid == 1000) req = 1'b0;
            end
        end
        req = 1'b0;
        n_cmp++; if (nvalid != 1000) begin n_err++; $display("FAIL b2b_timeout: got %0d valids want 1000", nvalid); end
        n_cmp++; if (fb_dut != fb_model) begin n_err++; $display("FAIL b2b_fallbacks: got %0d want %0d", fb_dut, fb_model); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid_search;
        bit stray;
        stray = 1'b0;
        seed_load = 1'b1; seed_in = 16'h1234; req = 1'b0; limit = 6'd1;
        @(negedge clk);
        seed_load = 1'b0; req = 1'b1;           // cycle T
        @(negedge clk);                         // T+1
        req = 1'b0;
        n_cmp++; if (busy !== 1'b1 || valid !== 1'b0) begin n_err++; $display("FAIL rs_t1: got busy=%b valid=%b want 1 0", busy, valid); end
        @(negedge clk);                         // T+2
        rst = 1'b1;
        n_cmp++; if (busy !== 1'b1 || valid !== 1'b0) begin n_err++; $display("FAIL rs_t2: got busy=%b valid=%b want 1 0", busy, valid); end
        @(negedge clk);                         // T+3
        n_cmp++; if (busy !== 1'b0 || valid !== 1'b0) begin n_err++; $display("FAIL rs_flags: got busy=%b valid=%b want 0 0", busy, valid); end
        n_cmp++; if (lfsr_state !== 16'hABCD) begin n_err++; $display("FAIL rs_lfsr: got %h want abcd", lfsr_state); end
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (valid !== 1'b0 || valid4 !== 1'b0) stray = 1'b1;
        end
        n_cmp++; if (stray) begin n_err++; $display("FAIL rs_no_valid: got a valid after reset, want none"); end
    endtask

    initial begin
        test_reset();
        test_seed_load();
        test_limit0();
        test_fallback();
        test_back_to_back();
        test_reset_mid_search();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lfsr_range_rng.md
LFSR_RANGE_RNG -- requirements
Module: lfsr_range_rng

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  - WIDTH, 16, LFSR width; legal values 8, 16, 24, 32.
  - OUT_W, 6, width of the range-limited output; legal range 1..WIDTH.
  - SEED, 16'hABCD truncated or zero-extended to WIDTH, reset and reload value; must be non-zero.
  - MAX_TRIES, 16, rejection attempts before fallback; legal range 1..255.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  - clk, in, 1, single clock; all state changes on posedge.
  - rst, in, 1, synchronous active-high reset.
  - seed_load, in, 1, load seed_in into the LFSR this cycle.
  - seed_in, in, WIDTH, new seed.
  - req, in, 1, request one range-limited number.
  - limit, in, OUT_W, exclusive upper bound; 0 means full range 2^OUT_W.
  - busy, out, 1, search in progress; req is ignored.
  - valid, out, 1, one-cycle pulse: rand_out is new.
  - rand_out, out, OUT_W, result, held until the next valid.
  - fallback, out, 1, qualifies valid: result came from the fallback path.
  - lfsr_state, out, WIDTH, current raw LFSR register.
REQ-003 Illegal parameter values SHALL stop elaboration with an error.

Function
REQ-004 The LFSR SHALL be Fibonacci, shift left by one, with the feedback bit entering bit 0 and equal to the XOR of the 1-indexed tap bits.
  - 8: 8,6,5,4
  - 16: 16,14,13,11 (bits 15,13,12,10)
  - 24: 24,23,22,17
  - 32: 32,22,2,1
REQ-005 The LFSR SHALL advance every non-reset cycle, free-running, independent of req and busy.
REQ-006 seed_load=1 SHALL load seed_in instead of advancing; seed_in=0 SHALL load SEED instead.
REQ-007 If the register is ever 0, the next value SHALL be SEED (lock-up guard).
REQ-008 The candidate SHALL be lfsr_state[OUT_W-1:0], sampled in the SEARCH cycle.
REQ-009 The FSM SHALL have two states, IDLE and SEARCH; busy=1 exactly while in SEARCH.
REQ-010 In IDLE, req=1 SHALL latch limit into limit_q, clear the try counter, and enter SEARCH next cycle.
REQ-011 In SEARCH, if limit_q=0 or candidate < limit_q, the FSM SHALL do all of the following next cycle:
  - rand_out <= candidate
  - valid = 1 and fallback = 0
  - return to IDLE
REQ-012 Otherwise the try counter SHALL increment and SEARCH SHALL continue.
  - On the MAX_TRIES-th consecutive reject: rand_out <= limit_q-1, valid = 1, fallback = 1, return to IDLE.
REQ-013 Latency SHALL be fixed as follows, with req sampled at cycle T:
  - first-try accept gives valid at T+2
  - worst case is valid at T+1+MAX_TRIES
REQ-014 req while busy=1 SHALL be ignored, with no queuing; limit changes during SEARCH SHALL have no effect.
REQ-015 req=1 in the same cycle valid=1 (state IDLE) SHALL be accepted.
REQ-016 seed_load during SEARCH SHALL NOT abort the search; subsequent candidates come from the reloaded stream.
REQ-017 valid and fallback SHALL be exactly one cycle wide; rand_out SHALL change only with valid.

Reset
REQ-018 rst=1 at a posedge SHALL take precedence over seed_load and req and SHALL set all of the following:
  - lfsr_state=SEED
  - state IDLE, busy=0
  - valid=0, fallback=0, rand_out=0
  - try counter=0, limit_q=0
REQ-019 rst asserted mid-SEARCH SHALL abandon the search with no valid pulse.
REQ-020 The first LFSR advance SHALL occur at the first posedge with rst=0.

Verification
REQ-021 The bench SHALL cover these directed scenarios (defaults unless stated):
  - Reset, then run free: lfsr_state = 0xABCD, 0x579A, 0xAF34 on consecutive cycles; valid=0, busy=0.
  - seed_load=1 with seed_in=0x0000, then 0x1234: state becomes 0xABCD, then 0x1234; next value follows REQ-004.
  - limit=0, req pulsed: valid at T+2; rand_out = lfsr_state[5:0] at T+1; fallback=0; busy high 1 cycle.
  - limit=1, MAX_TRIES=4, seed chosen so the four candidates are non-zero: valid at T+5, rand_out=0, fallback=1; extra req while busy produces no second valid.
  - limit=40, 1000 back-to-back requests (req held high): every rand_out < 40; valid spacing >= 2 cycles; fallback count matches a reference model exactly.
  - rst asserted at T+2 of a search: no valid; busy=0 and lfsr_state=0xABCD at the next cycle.
